// File: rtl/filterbank_sequencer.sv
// filterbank_sequencer: frame controller for the serial 16-band filterbank core.
// Accepts one sample per frame, strobes it into the tap delay line, walks the
// core through its MAC phases, then captures and serialises the band results.
module filterbank_sequencer #(
  parameter int unsigned NUM_PHASES = 49,
  parameter int unsigned NUM_BANDS  = 16,
  parameter int unsigned DATA_W     = 9,
  parameter int unsigned OUT_W      = 25,
  localparam int unsigned PHASE_W   = $clog2(NUM_PHASES),
  localparam int unsigned BAND_W    = $clog2(NUM_BANDS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clk_enable,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     shift_en,
  output logic signed [DATA_W-1:0] shift_data,
  output logic [PHASE_W-1:0]       phase,
  output logic                     phase_last,
  output logic                     acc_clear,
  output logic                     acc_dump,
  input  logic signed [OUT_W-1:0]  core_out [NUM_BANDS],
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic [BAND_W-1:0]        out_band,
  input  logic                     out_ready,
  output logic                     overrun
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
  localparam logic [BAND_W-1:0]  LAST_BAND  = BAND_W'(NUM_BANDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DUMP = 2'd2
  } state_t;

  state_t                  state;
  logic signed [OUT_W-1:0] buffer [NUM_BANDS];

  logic              drain_fire;
  logic              drain_last;
  logic              buf_free;
  logic [BAND_W-1:0] band_next;

  // Drain handshake decode; the buffer counts as free if its last band leaves this cycle
  always_comb begin
    drain_fire = out_valid && out_ready;
    drain_last = drain_fire && (out_band == LAST_BAND);
    buf_free   = !out_valid || drain_last;
    band_next  = out_band + BAND_W'(1);
  end

  // Frame FSM: accept sample, run MAC phases (stallable), one-cycle dump
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      phase      <= '0;
      shift_data <= '0;
      in_ready   <= 1'b0;
      shift_en   <= 1'b0;
      acc_clear  <= 1'b0;
      phase_last <= 1'b0;
      acc_dump   <= 1'b0;
    end else begin
      shift_en <= 1'b0;
      acc_dump <= 1'b0;
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            state      <= RUN;
            phase      <= '0;
            shift_data <= in_data;
            in_ready   <= 1'b0;
            shift_en   <= 1'b1;
            acc_clear  <= 1'b1;
            phase_last <= (NUM_PHASES == 1);
          end
        end
        RUN: begin
          // a low clk_enable freezes phase, acc_clear and phase_last
          if (clk_enable) begin
            acc_clear <= 1'b0;
            if (phase == LAST_PHASE) begin
              state      <= DUMP;
              phase      <= '0;
              phase_last <= 1'b0;
              acc_dump   <= 1'b1;
            end else begin
              phase      <= phase + PHASE_W'(1);
              phase_last <= (phase == LAST_PHASE - PHASE_W'(1));
            end
          end
        end
        DUMP: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  // Result buffer: capture on dump when free, otherwise flag overrun; serialise bands
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_band  <= '0;
      out_data  <= '0;
      overrun   <= 1'b0;
      for (int b = 0; b < int'(NUM_BANDS); b++) begin
        buffer[b] <= '0;
      end
    end else begin
      if (drain_fire) begin
        if (drain_last) begin
          out_valid <= 1'b0;
          out_band  <= '0;
          out_data  <= buffer[0];
        end else begin
          out_band <= band_next;
          out_data <= buffer[band_next];
        end
      end
      // capture takes priority over the drain update in the same cycle
      if (state == DUMP) begin
        if (buf_free) begin
          for (int b = 0; b < int'(NUM_BANDS); b++) begin
            buffer[b] <= core_out[b];
          end
          out_valid <= 1'b1;
          out_band  <= '0;
          out_data  <= core_out[0];
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule
